// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the vector ALU sequencer, the decode stage and the
// ALU itself: opcode encodings, default vector/lane geometry and the
// sequencer state enumeration.
//
// Optional feature macro: ALU_SEQ_RESULT_REG_EN (adds the S_WAIT state).
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  localparam int DEF_VEC_W  = 256;
  localparam int DEF_LANE_W = 16;
  localparam int N_LANES    = 16;

  localparam logic [3:0] OP_VADD = 4'b0000;
  localparam logic [3:0] OP_VDOT = 4'b0001;
  localparam logic [3:0] OP_SMUL = 4'b0010;
  localparam logic [3:0] OP_SST  = 4'b0011;
  localparam logic [3:0] OP_VLD  = 4'b0100;
  localparam logic [3:0] OP_VST  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SLH  = 4'b0111;
  localparam logic [3:0] OP_J    = 4'b1000;
  localparam logic [3:0] OP_NOP  = 4'b1111;

`ifdef ALU_SEQ_RESULT_REG_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXEC   = 3'd1,
    S_REDUCE = 3'd2,
    S_RESP   = 3'd3,
    S_WAIT   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXEC   = 3'd1,
    S_REDUCE = 3'd2,
    S_RESP   = 3'd3
  } state_t;
`endif

endpackage

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Multi-cycle sequencer owning the shared vector ALU. Accepts one
// instruction at a time, runs one ALU pass for ordinary ops, or a lane-wise
// multiply plus a four-pass halving tree reduction for VDOT, then holds the
// result until the consumer takes it.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      instruction handshake from decode
//   req_opcode, req_op1/2    instruction code and vector operands
//   alu_opcode, alu_op1/2    drive to the external ALU (NOP/0 when idle)
//   alu_result               combinational ALU result
//   resp_valid/resp_ready    result handshake to writeback
//   resp_result              final result, stable while resp_valid
//   busy                     high whenever not in S_IDLE
//
// Optional feature macro: ALU_SEQ_RESULT_REG_EN
//   When defined, alu_result is registered and every ALU pass is followed by
//   a S_WAIT cycle with the ALU drive held; the accumulator updates at the
//   end of S_WAIT.
// ---------------------------------------------------------------------------
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int VEC_W  = DEF_VEC_W,
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_opcode,
  input  logic [VEC_W-1:0] req_op1,
  input  logic [VEC_W-1:0] req_op2,
  output logic [3:0]       alu_opcode,
  output logic [VEC_W-1:0] alu_op1,
  output logic [VEC_W-1:0] alu_op2,
  input  logic [VEC_W-1:0] alu_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [VEC_W-1:0] resp_result,
  output logic             busy
);

  localparam int SH_W = $clog2(VEC_W);

  state_t             r_state;
  state_t             w_state_nx;
  logic [3:0]         r_opc;
  logic [VEC_W-1:0]   r_op1;
  logic [VEC_W-1:0]   r_op2;
  logic [VEC_W-1:0]   r_acc;
  logic [1:0]         r_k;
  logic [VEC_W-1:0]   r_resp_result;

  logic [SH_W-1:0]    w_shamt;
  logic [VEC_W-1:0]   w_red_op2;
  logic               w_pass_done;   // accumulator captures this cycle
  logic               w_pass_red;    // the completing pass is a reduction
  logic [VEC_W-1:0]   w_cap_val;
  logic               w_resp_load;

`ifdef ALU_SEQ_RESULT_REG_EN
  logic [VEC_W-1:0]   r_alu_res;
  logic               r_wait_red;    // S_WAIT follows a reduction pass

  assign w_pass_done = (r_state == S_WAIT);
  assign w_pass_red  = r_wait_red;
  assign w_cap_val   = r_alu_res;
`else
  assign w_pass_done = (r_state == S_EXEC) || (r_state == S_REDUCE);
  assign w_pass_red  = (r_state == S_REDUCE);
  assign w_cap_val   = alu_result;
`endif

  // Reduction pass k folds the upper half of the still-live span onto the
  // lower half: shift by VEC_W/2, VEC_W/4, ... with zero fill.
  assign w_shamt     = SH_W'(VEC_W / 2) >> r_k;
  assign w_red_op2   = r_acc >> w_shamt;

  // The result register is loaded on the same edge the FSM enters S_RESP.
  assign w_resp_load = w_pass_done && (w_state_nx == S_RESP);

  assign req_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign resp_valid  = (r_state == S_RESP);
  assign resp_result = r_resp_result;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_state_nx = S_EXEC;
        else           w_state_nx = S_IDLE;
      end
      S_EXEC: begin
`ifdef ALU_SEQ_RESULT_REG_EN
        w_state_nx = S_WAIT;
`else
        if (r_opc == OP_VDOT) w_state_nx = S_REDUCE;
        else                  w_state_nx = S_RESP;
`endif
      end
      S_REDUCE: begin
`ifdef ALU_SEQ_RESULT_REG_EN
        w_state_nx = S_WAIT;
`else
        if (r_k == 2'd3) w_state_nx = S_RESP;
        else             w_state_nx = S_REDUCE;
`endif
      end
`ifdef ALU_SEQ_RESULT_REG_EN
      S_WAIT: begin
        if (r_wait_red) begin
          if (r_k == 2'd3) w_state_nx = S_RESP;
          else             w_state_nx = S_REDUCE;
        end else begin
          if (r_opc == OP_VDOT) w_state_nx = S_REDUCE;
          else                  w_state_nx = S_RESP;
        end
      end
`endif
      S_RESP: begin
        if (resp_ready) w_state_nx = S_IDLE;
        else            w_state_nx = S_RESP;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // ALU operand/opcode drive; NOP with zero operands outside active passes.
  always_comb begin
    alu_opcode = OP_NOP;
    alu_op1    = {VEC_W{1'b0}};
    alu_op2    = {VEC_W{1'b0}};
    case (r_state)
      S_EXEC: begin
        alu_opcode = r_opc;
        alu_op1    = r_op1;
        alu_op2    = r_op2;
      end
      S_REDUCE: begin
        alu_opcode = OP_VADD;
        alu_op1    = r_acc;
        alu_op2    = w_red_op2;
      end
`ifdef ALU_SEQ_RESULT_REG_EN
      // Hold the drive of the pass being waited on; r_acc and r_k are
      // unchanged until the end of S_WAIT so recomputing is equivalent.
      S_WAIT: begin
        if (r_wait_red) begin
          alu_opcode = OP_VADD;
          alu_op1    = r_acc;
          alu_op2    = w_red_op2;
        end else begin
          alu_opcode = r_opc;
          alu_op1    = r_op1;
          alu_op2    = r_op2;
        end
      end
`endif
      default: begin
        alu_opcode = OP_NOP;
        alu_op1    = {VEC_W{1'b0}};
        alu_op2    = {VEC_W{1'b0}};
      end
    endcase
  end

  // Instruction latch, accumulator, pass counter and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opc         <= OP_NOP;
      r_op1         <= {VEC_W{1'b0}};
      r_op2         <= {VEC_W{1'b0}};
      r_acc         <= {VEC_W{1'b0}};
      r_k           <= 2'd0;
      r_resp_result <= {VEC_W{1'b0}};
    end else begin
      if ((r_state == S_IDLE) && req_valid) begin
        r_opc <= req_opcode;
        r_op1 <= req_op1;
        r_op2 <= req_op2;
      end
      if (w_pass_done) begin
        r_acc <= w_cap_val;
        // The EXEC pass arms the counter; each reduction pass advances it.
        if (w_pass_red) r_k <= r_k + 2'd1;
        else            r_k <= 2'd0;
      end
      if (w_resp_load) begin
        // VDOT: the dot product sits in lane 0; upper lanes hold partials.
        if (r_opc == OP_VDOT) begin
          r_resp_result <= {{(VEC_W-LANE_W){1'b0}}, w_cap_val[LANE_W-1:0]};
        end else begin
          r_resp_result <= w_cap_val;
        end
      end
    end
  end

`ifdef ALU_SEQ_RESULT_REG_EN
  // Registered ALU result and the pass-kind tag for S_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_res  <= {VEC_W{1'b0}};
      r_wait_red <= 1'b0;
    end else begin
      r_alu_res <= alu_result;
      if (r_state == S_EXEC)        r_wait_red <= 1'b0;
      else if (r_state == S_REDUCE) r_wait_red <= 1'b1;
      else                          r_wait_red <= r_wait_red;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Directed bench for alu_seq. Provides a small behavioural ALU (positive
// normal half-precision add/multiply per lane, integer add for SST, zero for
// NOP and everything else) and checks results, latencies, handshakes, ALU
// drive and reset behaviour against hand-computed values.
// ---------------------------------------------------------------------------
module tb_alu_seq;
  import alu_seq_pkg::*;

`ifdef ALU_SEQ_RESULT_REG_EN
  localparam int LAT_SINGLE   = 3;
  localparam int LAT_VDOT     = 11;
  localparam int NONNOP_VDOT  = 10;
  localparam int TICKS_TO_K2  = 6;
`else
  localparam int LAT_SINGLE   = 2;
  localparam int LAT_VDOT     = 6;
  localparam int NONNOP_VDOT  = 5;
  localparam int TICKS_TO_K2  = 3;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_opcode;
  logic [255:0] req_op1, req_op2;
  logic [3:0]   alu_opcode;
  logic [255:0] alu_op1, alu_op2;
  logic [255:0] alu_result;
  logic         resp_valid;
  logic         resp_ready;
  logic [255:0] resp_result;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int nonnop_cnt = 0;

  alu_seq dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .alu_opcode (alu_opcode),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_result (alu_result),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    logic [11:0] ma, mb, s;
    int d;
    if (a[14:0] == 15'd0) return b;
    if (b[14:0] == 15'd0) return a;
    if (a[14:10] >= b[14:10]) begin x = a; y = b; end
    else begin x = b; y = a; end
    d  = int'(x[14:10]) - int'(y[14:10]);
    ma = {2'b01, x[9:0]};
    mb = {2'b01, y[9:0]} >> d;
    s  = ma + mb;
    if (s[11]) return {1'b0, x[14:10] + 5'd1, s[10:1]};
    else       return {1'b0, x[14:10], s[9:0]};
  endfunction

  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic [21:0] p;
    int e;
    if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return 16'd0;
    p = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) return {1'b0, 5'(e + 1), p[20:11]};
    else       return {1'b0, 5'(e), p[19:10]};
  endfunction

  function automatic logic [255:0] fill(input logic [15:0] lane);
    return {16{lane}};
  endfunction

  // Behavioural external ALU.
  always_comb begin
    alu_result = 256'd0;
    case (alu_opcode)
      OP_VADD: for (int i = 0; i < 16; i++)
                 alu_result[i*16 +: 16] = fp16_add(alu_op1[i*16 +: 16], alu_op2[i*16 +: 16]);
      OP_VDOT: for (int i = 0; i < 16; i++)
                 alu_result[i*16 +: 16] = fp16_mul(alu_op1[i*16 +: 16], alu_op2[i*16 +: 16]);
      OP_SST:  alu_result = alu_op1 + alu_op2;
      default: alu_result = 256'd0;
    endcase
  end

  // Count cycles in which the ALU is driven with a real opcode.
  always @(negedge clk) begin
    if (alu_opcode !== OP_NOP) nonnop_cnt <= nonnop_cnt + 1;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction; returns in cycle 1 (the EXEC cycle).
  task automatic send(input logic [3:0] op, input logic [255:0] a, input logic [255:0] b);
    check("req_ready_before_send", {255'd0, req_ready}, 256'd1);
    req_valid  = 1'b1;
    req_opcode = op;
    req_op1    = a;
    req_op2    = b;
    tick();
    req_valid  = 1'b0;
    req_opcode = 4'd0;
    req_op1    = 256'd0;
    req_op2    = 256'd0;
  endtask

  // Cycle index (accept edge = 0) in which resp_valid is first seen.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int cnt0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_opcode = 4'd0;
    req_op1    = 256'd0;
    req_op2    = 256'd0;
    resp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_req_ready", {255'd0, req_ready}, 256'd1);
    check("rst_busy", {255'd0, busy}, 256'd0);
    check("rst_resp_valid", {255'd0, resp_valid}, 256'd0);
    check("rst_resp_result", resp_result, 256'd0);
    check("rst_alu_opcode", {252'd0, alu_opcode}, {252'd0, OP_NOP});
    tick();

    // VADD 1.0 + 1.0 = 2.0 in every lane
    send(OP_VADD, fill(16'h3C00), fill(16'h3C00));
    check("vadd_exec_opcode", {252'd0, alu_opcode}, {252'd0, OP_VADD});
    check("vadd_exec_op1", alu_op1, fill(16'h3C00));
    check("vadd_exec_busy", {255'd0, busy}, 256'd1);
    check("vadd_exec_req_ready", {255'd0, req_ready}, 256'd0);
    wait_resp(lat);
    check("vadd_latency", 256'(lat), 256'(LAT_SINGLE));
    check("vadd_result", resp_result, fill(16'h4000));
    check("vadd_resp_alu_nop", {252'd0, alu_opcode}, {252'd0, OP_NOP});
    tick();
    check("vadd_back_idle", {255'd0, req_ready}, 256'd1);
    check("vadd_resp_dropped", {255'd0, resp_valid}, 256'd0);

    // VDOT of ones: sixteen products of 1.0 reduce to 16.0 (0x4C00)
    cnt0 = nonnop_cnt;
    send(OP_VDOT, fill(16'h3C00), fill(16'h3C00));
    wait_resp(lat);
    check("vdot_latency", 256'(lat), 256'(LAT_VDOT));
    check("vdot_result", resp_result, 256'h4C00);
    check("vdot_alu_cycles", 256'(nonnop_cnt - cnt0), 256'(NONNOP_VDOT));
    tick();

    // VDOT of 2.0*1.0: sum 32.0 (0x5000); also proves the pass counter rearms
    send(OP_VDOT, fill(16'h4000), fill(16'h3C00));
    wait_resp(lat);
    check("vdot2_latency", 256'(lat), 256'(LAT_VDOT));
    check("vdot2_result", resp_result, 256'h5000);
    tick();

    // Backpressure: SST 5+7 held for 10 cycles
    resp_ready = 1'b0;
    send(OP_SST, 256'd5, 256'd7);
    wait_resp(lat);
    check("sst_latency", 256'(lat), 256'(LAT_SINGLE));
    check("sst_result", resp_result, 256'd12);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_resp_valid", {255'd0, resp_valid}, 256'd1);
      check("bp_result_stable", resp_result, 256'd12);
      check("bp_req_ready", {255'd0, req_ready}, 256'd0);
      check("bp_alu_nop", {252'd0, alu_opcode}, {252'd0, OP_NOP});
    end
    resp_ready = 1'b1;
    tick();
    check("bp_release_req_ready", {255'd0, req_ready}, 256'd1);

    // Reset during reduction pass 2
    send(OP_VDOT, fill(16'h3C00), fill(16'h3C00));
    for (int i = 0; i < TICKS_TO_K2; i++) tick();
    check("k2_alu_vadd", {252'd0, alu_opcode}, {252'd0, OP_VADD});
    check("k2_busy", {255'd0, busy}, 256'd1);
    rst = 1'b1;
    tick();
    check("midrst_resp_valid", {255'd0, resp_valid}, 256'd0);
    check("midrst_busy", {255'd0, busy}, 256'd0);
    check("midrst_alu_nop", {252'd0, alu_opcode}, {252'd0, OP_NOP});
    check("midrst_resp_result", resp_result, 256'd0);
    rst = 1'b0;
    check("midrst_req_ready", {255'd0, req_ready}, 256'd1);

    // VADD after reset: 2.0 + 1.0 = 3.0 (0x4200)
    send(OP_VADD, fill(16'h4000), fill(16'h3C00));
    wait_resp(lat);
    check("post_rst_vadd_latency", 256'(lat), 256'(LAT_SINGLE));
    check("post_rst_vadd_result", resp_result, fill(16'h4200));
    tick();

    // NOP and undefined opcode: ALU returns 0
    send(OP_NOP, fill(16'h1234), fill(16'h5678));
    wait_resp(lat);
    check("nop_latency", 256'(lat), 256'(LAT_SINGLE));
    check("nop_result", resp_result, 256'd0);
    tick();
    send(4'b1010, 256'd9, 256'd3);
    wait_resp(lat);
    check("undef_latency", 256'(lat), 256'(LAT_SINGLE));
    check("undef_result", resp_result, 256'd0);
    tick();
    check("final_idle", {255'd0, req_ready}, 256'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Multi-cycle sequencer that owns the shared 256-bit vector ALU and drives its operand and opcode ports. It accepts one instruction at a time from the decode stage over a valid/ready handshake. Single-pass ops take one ALU pass. VDOT takes a lane-wise multiply followed by a four-pass tree reduction through the same ALU. The block sits between decode/operand fetch and writeback; the ALU is instantiated by the parent and connected to the `alu_*` ports.

## Interface
- VEC_W, 256: vector width in bits.
- LANE_W, 16: lane width in bits (half-precision float).
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  instruction offered.
- req_ready  out  1  sequencer can accept.
- req_opcode  in  4  instruction code (VADD 0000 … J 1000, NOP 1111).
- req_op1, req_op2  in  VEC_W  operands.
- alu_opcode  out  4  to ALU.
- alu_op1, alu_op2  out  VEC_W  to ALU.
- alu_result  in  VEC_W  from ALU (combinational).
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_result  out  VEC_W  final result.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, EXEC, REDUCE, RESP. An extra WAIT state exists only with the macro enabled.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, latch opcode and operands, then go to EXEC.
- EXEC: drive `alu_opcode`=latched opcode and `alu_op1`/`alu_op2`=latched operands. Capture `alu_result` into the accumulator `acc`.
  - If opcode = VDOT (0001): set pass counter k=0 and go to REDUCE.
  - Otherwise: go to RESP.
- REDUCE pass k (0..3): drive `alu_opcode`=VADD, `alu_op1`=`acc`, `alu_op2`=`acc >> (128 >> k)` (logical, zero fill). Capture the result into `acc`. After k=3, go to RESP.
- RESP entry for VDOT: `resp_result` = {240'd0, acc[15:0]}.
- RESP entry for all other opcodes: `resp_result` = `acc` unchanged. This includes NOP and undefined codes, for which the ALU returns 0.
- RESP: `resp_valid`=1 and held until `resp_ready`. On handshake, return to IDLE. `resp_result` stays stable while `resp_valid` is high.
- `req_ready`=0 outside IDLE; back-to-back requests are not overlapped.
- Outside EXEC/REDUCE: `alu_opcode`=NOP (1111) and `alu_op1`/`alu_op2`=0.
- Reset (any state, mid-operation included): next state IDLE, `acc`=0, k=0, `resp_valid`=0, `resp_result`=0, `busy`=0, `req_ready`=1 after the reset cycle. Any in-flight instruction is discarded.

## Timing
- Request accepted at edge 0 → EXEC cycle 1.
- Single-pass op: `resp_valid` rises in cycle 2. Latency is 2 cycles from accept to `resp_valid`.
- VDOT: EXEC cycle 1, REDUCE cycles 2–5, `resp_valid` in cycle 6.
- `resp_ready` already high in the first RESP cycle → IDLE next cycle. Earliest next accept is 1 cycle after the response handshake.
- `resp_ready` low → RESP held indefinitely with no change to any output.

## Configuration
- ALU_SEQ_RESULT_REG_EN defined:
  - `alu_result` is registered before capture.
  - Each EXEC and REDUCE pass is followed by one WAIT cycle in which `alu_*` outputs hold their values. `acc` updates at the end of WAIT.
  - Single-pass latency is 3 cycles; VDOT latency is 11 cycles.
- ALU_SEQ_RESULT_REG_EN undefined: no WAIT state, timing exactly as above.

## Structure
- Shared package `alu_seq_pkg` holds:
  - opcode localparams (VADD, VDOT, SMUL, SST, VLD, VST, SLL, SLH, J, NOP);
  - VEC_W/LANE_W defaults and N_LANES=16;
  - the state enum.
- Decode and the ALU use the same opcode constants from this package.
- No sub-module. FSM, pass counter and operand muxing live in one module. The ALU stays outside.

## Test plan
- VADD: op1 all lanes 0x3C00, op2 all lanes 0x3C00 → `resp_result` all lanes 0x4000, `resp_valid` 2 cycles after accept.
- VDOT: both operands all lanes 0x3C00 → `resp_result`=0x…0004C00 (16.0 in lane 0, upper 240 bits zero). Exactly 5 non-NOP `alu_opcode` cycles, `resp_valid` in cycle 6.
- Backpressure: `resp_ready` held 0 for 10 cycles after SST 5+7 → `resp_result`=12 stable, `req_ready`=0 throughout; `req_ready`=1 the cycle after `resp_ready` rises.
- Reset during REDUCE pass 2 → next cycle IDLE, `resp_valid`=0, `busy`=0. A new VADD then completes normally.
- NOP and undefined opcode 1010 → `resp_result`=0 after 2 cycles.
- With ALU_SEQ_RESULT_REG_EN: repeat the VDOT case → same 0x4C00 result, `resp_valid` 11 cycles after accept.
